// File: rtl/mod_intvec_pkg.sv
// Shared register offsets, FSM encoding and VEC field layout for the interrupt vector controller.
// Pure definitions, no logic.
package mod_intvec_pkg;

    localparam logic [31:0] OFS_MASK = 32'h0;
    localparam logic [31:0] OFS_PEND = 32'h4;
    localparam logic [31:0] OFS_VEC  = 32'h8;
    localparam logic [31:0] OFS_CTRL = 32'hC;

    localparam int VEC_INS_BIT = 31;
    localparam int VEC_ID_W    = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SERV = 2'd2
    } state_t;

    function automatic logic [31:0] vec_word(input logic ins, input logic [VEC_ID_W-1:0] id);
        vec_word = '0;
        vec_word[VEC_INS_BIT] = ins;
        vec_word[VEC_ID_W-1:0] = id;
    endfunction

endpackage

// File: rtl/mod_intvec_pri.sv
// Combinational circular priority search: first set request at or after start wins.
// Zero latency; no flow control.
module mod_intvec_pri
    import mod_intvec_pkg::*;
#(
    parameter int N_SRC = 8
) (
    input  logic [N_SRC-1:0]    req,
    input  logic [VEC_ID_W-1:0] start,
    output logic [VEC_ID_W-1:0] idx,
    output logic                vld
);

    int j;

    always_comb begin
        idx = '0;
        vld = 1'b0;
        j   = 0;
        for (int i = 0; i < N_SRC; i++) begin
            j = int'(start) + i;
            if (j >= N_SRC) j = j - N_SRC;
            if (!vld && req[j]) begin
                vld = 1'b1;
                idx = j[VEC_ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mod_intvec.sv
// Vectored interrupt controller, state on negedge clk; int rises one clock after a qualifying pending source.
// No backpressure; INTVEC_ROUND_ROBIN_EN selects rotating priority, otherwise fixed lowest-index priority.
module mod_intvec
    import mod_intvec_pkg::*;
#(
    parameter int N_SRC = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ie,
    input  logic             de,
    input  logic [31:0]      iaddr,
    input  logic [31:0]      daddr,
    input  logic [1:0]       drw,
    input  logic [31:0]      din,
    output logic [31:0]      iout,
    output logic [31:0]      dout,
    output logic             int_req,   // "int" is a reserved word
    input  logic             int_ack,
    input  logic [N_SRC-1:0] i_src
);

    state_t                state, state_nxt;
    logic [N_SRC-1:0]      mask, pend, src_q, src_rise, ack_clr, w1c;
    logic                  gie, vec_ins;
    logic [VEC_ID_W-1:0]   vec_id, ptr, win_idx;
    logic                  win_vld, wr, wr_mask, wr_pend, wr_vec, wr_ctrl;
    logic                  take, ack, eoi;
    logic                  unused_bits;

    assign wr      = de & drw[0];
    assign wr_mask = wr && (daddr == OFS_MASK);
    assign wr_pend = wr && (daddr == OFS_PEND);
    assign wr_vec  = wr && (daddr == OFS_VEC);
    assign wr_ctrl = wr && (daddr == OFS_CTRL);

    assign take = (state == ST_IDLE) && gie && win_vld;
    assign ack  = (state == ST_REQ) && int_ack;
    assign eoi  = (state == ST_SERV) && wr_vec;

    assign src_rise = i_src & ~src_q;
    assign ack_clr  = ack ? ({{(N_SRC-1){1'b0}}, 1'b1} << vec_id) : '0;
    assign w1c      = wr_pend ? din[N_SRC-1:0] : '0;

`ifdef INTVEC_ROUND_ROBIN_EN
    always_ff @(negedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (ack)
            ptr <= (vec_id == VEC_ID_W'(N_SRC-1)) ? '0 : vec_id + 1'b1;
    end
`else
    assign ptr = '0;
`endif

    mod_intvec_pri #(.N_SRC(N_SRC)) u_pri (
        .req   (pend & mask),
        .start (ptr),
        .idx   (win_idx),
        .vld   (win_vld)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (take) state_nxt = ST_REQ;
            ST_REQ:  if (int_ack) state_nxt = ST_SERV;
            ST_SERV: if (eoi) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // New edges are OR-ed in last so they survive a same-edge W1C or acknowledge.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            mask    <= '0;
            pend    <= '0;
            src_q   <= '0;
            gie     <= 1'b0;
            vec_id  <= '0;
            vec_ins <= 1'b0;
        end else begin
            src_q <= i_src;
            pend  <= (pend & ~w1c & ~ack_clr) | src_rise;
            if (wr_mask) mask <= din[N_SRC-1:0];
            if (wr_ctrl)  gie <= din[0];
            else if (eoi) gie <= 1'b1;
            else if (ack) gie <= 1'b0;
            if (take) vec_id <= win_idx;
            if (ack)      vec_ins <= 1'b1;
            else if (eoi) vec_ins <= 1'b0;
        end
    end

    always_comb begin
        dout = '0;
        if (de) begin
            case (daddr)
                OFS_MASK: dout = 32'(mask);
                OFS_PEND: dout = 32'(pend);
                OFS_VEC:  dout = vec_word(vec_ins, vec_id);
                OFS_CTRL: dout = {31'd0, gie};
                default:  dout = '0;
            endcase
        end
    end

    assign iout        = '0;
    assign int_req     = (state == ST_REQ);
    assign unused_bits = ^{ie, iaddr, drw[1], din};

endmodule

// File: tb/tb_mod_intvec.sv
// Bench for mod_intvec: directed scenarios plus random traffic against a behavioural model.
module tb_mod_intvec;
    localparam int N = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ie, de, int_ack, int_req;
    logic [31:0]   iaddr, daddr, din, iout, dout;
    logic [1:0]    drw;
    logic [N-1:0]  i_src;

    int n_tests = 0;
    int n_fail  = 0;

    int           m_state;   // 0 idle, 1 requesting, 2 in service
    logic [N-1:0] m_mask, m_pend, m_prev;
    bit           m_gie, m_ins;
    int           m_vec, m_ptr;

    always #50 clk = ~clk;

    mod_intvec #(.N_SRC(N)) dut (
        .clk(clk), .rst(rst), .ie(ie), .de(de), .iaddr(iaddr), .daddr(daddr),
        .drw(drw), .din(din), .iout(iout), .dout(dout), .int_req(int_req),
        .int_ack(int_ack), .i_src(i_src)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int start);
        for (int k = 0; k < N; k++)
            if (r[(start + k) % N]) return (start + k) % N;
        return -1;
    endfunction

    function automatic logic [31:0] mread(input logic [31:0] a);
        if (!de) return 32'd0;
        case (a)
            32'h0:   return 32'(m_mask);
            32'h4:   return 32'(m_pend);
            32'h8:   return {m_ins, 26'd0, 5'(m_vec)};
            32'hC:   return {31'd0, m_gie};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_state = 0; m_mask = '0; m_pend = '0; m_prev = '0;
        m_gie = 0; m_ins = 0; m_vec = 0; m_ptr = 0;
    endtask

    task automatic model_step();
        bit           w;
        int           win;
        logic [N-1:0] p, rise;
        w    = de && drw[0];
        rise = i_src & ~m_prev;
        win  = pick(m_pend & m_mask, m_ptr);
        p    = m_pend;
        if (m_state == 0 && m_gie && win >= 0) begin
            m_vec = win; m_state = 1;
        end else if (m_state == 1 && int_ack) begin
            p[m_vec] = 1'b0; m_gie = 0; m_ins = 1; m_state = 2;
`ifdef INTVEC_ROUND_ROBIN_EN
            m_ptr = (m_vec + 1) % N;
`endif
        end else if (m_state == 2 && w && daddr == 32'h8) begin
            m_gie = 1; m_ins = 0; m_state = 0;
        end
        if (w && daddr == 32'h0) m_mask = din[N-1:0];
        if (w && daddr == 32'h4) p = p & ~din[N-1:0];
        if (w && daddr == 32'hC) m_gie = din[0];
        m_pend = p | rise;
        m_prev = i_src;
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        de = 1; drw = 2'b01; daddr = a; din = d;
        tick();
        de = 0; drw = 2'b00; din = 0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        de = 1; drw = 2'b10; daddr = a;
        #1;
        d = dout;
        de = 0; drw = 2'b00;
    endtask

    task automatic ack_cycle();
        int_ack = 1;
        tick();
        int_ack = 0;
    endtask

    task automatic check_all(input string tag);
        logic [31:0] d;
        logic [31:0] addrs[4] = '{32'h0, 32'h4, 32'h8, 32'hC};
        for (int k = 0; k < 4; k++) begin
            de = 1; drw = 2'b10; daddr = addrs[k];
            #1;
            d = dout;
            check($sformatf("%s_r%0h", tag, addrs[k]), d, mread(addrs[k]));
            de = 0; drw = 2'b00;
        end
        check({tag, "_int"}, 32'(int_req), 32'(m_state == 1));
    endtask

    task automatic wait_int(input string tag);
        for (int k = 0; k < 30 && !int_req; k++) tick();
        check(tag, 32'(int_req), 32'd1);
    endtask

    initial begin
        logic [31:0] d;
        int exp_order[4];
        ie = 0; de = 0; drw = 0; iaddr = 0; daddr = 0; din = 0; int_ack = 0; i_src = '0;
        model_reset();
        #1 rst = 1;
        #3;
        check("rst_int", 32'(int_req), 32'd0);
        check("iout", iout, 32'd0);
        check_all("rst");
        rst = 0;
        @(posedge clk); #1;

        // two simultaneous edges, masked to sources 1 and 2
        wr(32'hC, 1); wr(32'h0, 32'h06);
        i_src = 8'h06; tick();
        rd(32'h4, d); check("pair_pend", d, 32'h6);
        check("pair_int_early", 32'(int_req), 32'd0);
        tick();
        check("pair_int", 32'(int_req), 32'd1);
        rd(32'h8, d); check("pair_vec", d, 32'h1);
        ack_cycle();
        rd(32'h4, d); check("pair_pend_ack", d, 32'h4);
        rd(32'hC, d); check("pair_gie_ack", d, 32'h0);
        rd(32'h8, d); check("pair_vec_ins", d, 32'h8000_0001);
        wr(32'h8, 0);
        rd(32'hC, d); check("pair_gie_eoi", d, 32'h1);
        tick();
        rd(32'h8, d); check("pair_vec2", d, 32'h2);
        check_all("pair");
        ack_cycle(); wr(32'h8, 0);
        i_src = '0; tick();
        check_all("pair_done");

        // W1C colliding with a new edge
        wr(32'hC, 0);
        i_src = 8'h20; wr(32'h4, 32'h20);
        rd(32'h4, d); check("w1c_edge", d, 32'h20);
        i_src = '0; wr(32'h4, 32'hFF);
        check_all("w1c");

        // masking the winner while requesting does not withdraw int
        wr(32'h0, 32'h10);
        i_src = 8'h10; tick();
        wr(32'hC, 1);
        tick();
        rd(32'h8, d); check("hold_vec", d, 32'h4);
        wr(32'h0, 0);
        check("hold_int", 32'(int_req), 32'd1);
        ack_cycle();
        rd(32'h4, d); check("hold_pend", d, 32'h0);
        check_all("hold");

        // stray ack in service, stray EOI in idle, unmapped read
        ack_cycle();
        check_all("stray_ack");
        wr(32'h8, 0);
        wr(32'h8, 0);
        check_all("stray_eoi");
        rd(32'h10, d); check("unmapped", d, 32'h0);

        // reset while in service
        wr(32'h0, 32'h10);
        i_src = '0; tick();
        i_src = 8'h10; tick();
        wait_int("rst_wait");
        ack_cycle();
        check("serv_reached", 32'(m_state), 32'd2);
        #2 rst = 1;
        model_reset();
        #1;
        check("rst_serv_int", 32'(int_req), 32'd0);
        rd(32'h0, d); check("rst_serv_mask", d, 32'h0);
        rd(32'h4, d); check("rst_serv_pend", d, 32'h0);
        rd(32'h8, d); check("rst_serv_vec", d, 32'h0);
        rd(32'hC, d); check("rst_serv_ctrl", d, 32'h0);
        i_src = '0;
        rst = 0;

        // repeated service of sources 0 and 3
`ifdef INTVEC_ROUND_ROBIN_EN
        exp_order = '{0, 3, 0, 3};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        wr(32'h0, 32'hFF); wr(32'hC, 1);
        i_src = 8'h09; tick();
        for (int r = 0; r < 4; r++) begin
            wait_int($sformatf("rr_wait%0d", r));
            rd(32'h8, d); check($sformatf("rr_order%0d", r), d, 32'(exp_order[r]));
            ack_cycle();
            i_src = '0; tick();
            i_src = 8'h09; tick();
            wr(32'h8, 0);
        end
        check_all("rr");

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] tbl[5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
            if ($urandom_range(0, 3) == 0) i_src = N'($urandom);
            de      = ($urandom_range(0, 7) != 0);
            daddr   = tbl[$urandom_range(0, 4)];
            drw     = {1'b1, ($urandom_range(0, 3) == 0)};
            din     = $urandom;
            if (daddr == 32'hC) din[0] = ($urandom_range(0, 3) != 0);
            if (daddr == 32'h4) din = din & $urandom;
            int_ack = ($urandom_range(0, 2) == 0);
            #1;
            check("rnd_dout", dout, mread(daddr));
            check("rnd_int", 32'(int_req), 32'(m_state == 1));
            tick();
        end
        de = 0; drw = 0; int_ack = 0;
        check_all("end");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
